spi_burst_sequencer: RTL and testbench
======================================

Name: spi_burst_sequencer

Overview:
- Upstream feeder for the single-byte SPI master.
- Buffers up to DEPTH command bytes in a TX FIFO, issues them to the master one at a time, and collects each received byte into an RX FIFO.
- Host logic performs multi-byte bursts through simple FIFO push/pop ports and never handshakes with the master directly.

Parameters:
- DEPTH, 8, entries in each of the TX and RX FIFOs. Power of two, minimum 2.
- AW, 3, log2(DEPTH). Level outputs are AW+1 bits wide.
- TO_CYCLES, 64, watchdog limit in clk cycles. Used only with SPI_SEQ_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  push wr_data into the TX FIFO.
- wr_data  in  8  TX byte.
- tx_full  out  1  TX FIFO full.
- tx_level  out  AW+1  TX FIFO occupancy.
- rd_en  in  1  pop the RX FIFO.
- rd_data  out  8  RX FIFO head (first-word fall-through).
- rx_empty  out  1  RX FIFO empty.
- rx_level  out  AW+1  RX FIFO occupancy.
- go  in  1  start a burst of len bytes (single-cycle pulse).
- len  in  AW+1  burst length, legal range 1..DEPTH.
- seq_busy  out  1  burst in progress.
- done  out  1  one-cycle pulse when the burst completes.
- err  out  1  one-cycle pulse on a rejected go or a timeout.
- m_start  out  1  to master start.
- m_data_in  out  8  to master data_in.
- m_busy  in  1  from master busy.
- m_data_out  in  8  from master data_out.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State IDLE; both FIFOs emptied; counters cleared.
  - tx_full=0, rx_empty=1, both levels 0, seq_busy=0, done=0, err=0, m_start=0, m_data_in=0x00.
  - A burst interrupted by reset is discarded entirely.
- FIFOs: circular, AW-bit pointers wrapping modulo DEPTH, with an AW+1 bit count.
  - Push when full: ignored. Pop when empty: ignored. Neither changes state.
  - Push and pop in the same cycle on a non-full, non-empty FIFO leaves the count unchanged.
  - TX full with a simultaneous internal pop: the pop occurs, the push is ignored.
- go acceptance (sampled only in IDLE): accepted iff 1<=len<=tx_level and len<=DEPTH-rx_level.
  - Otherwise: err pulses the next cycle and state stays IDLE.
  - go while seq_busy=1: ignored, no err.
- State machine:
  - IDLE: on accepted go, load remaining=len, seq_busy<=1, go to ISSUE.
  - ISSUE: m_data_in<=TX head, m_start=1 for exactly this one cycle, go to WAIT_BUSY.
  - WAIT_BUSY: hold m_data_in; on m_busy=1 go to WAIT_DONE.
  - WAIT_DONE: on m_busy=0, push m_data_out into the RX FIFO, pop the TX FIFO, decrement remaining, go to STORE.
  - STORE: if remaining=0, go to FINISH; else go to ISSUE.
  - FINISH: done pulse, seq_busy<=0, go to IDLE.
- m_data_in is held stable from ISSUE until the TX pop. The master samples data_in one cycle after start, and this hold covers that.
- Master-facing overhead: ISSUE plus STORE add 2 cycles per byte beyond the master's own transfer time.
- Host traffic during a burst:
  - Host wr_en/rd_en remain legal.
  - The acceptance check guarantees RX space, so RX never overflows within a burst.

Optional Feature:
- Macro SPI_SEQ_TIMEOUT_EN.
- When defined:
  - A cycle counter runs in WAIT_BUSY and WAIT_DONE and clears on every state change.
  - Reaching TO_CYCLES aborts the burst: err pulses, seq_busy<=0, state returns to IDLE.
  - The unsent current byte and the rest of the burst remain in the TX FIFO; bytes already received remain in the RX FIFO.
- When undefined: no counter is synthesised, the block waits on m_busy indefinitely, and err flags only rejected go.

Test Plan:
- Reset mid-burst: assert rst_n=0 during WAIT_DONE of byte 2 of 4 -> all outputs at reset values immediately, tx_level=0, rx_level=0, m_start=0.
- Loopback burst: paired spi_master with miso tied to mosi; push 0xA5, 0x3C, 0x0F; go len=3 -> exactly 3 single-cycle m_start pulses; RX reads 0xA5, 0x3C, 0x0F; one done pulse; tx_level=0.
- Illegal go:
  - tx_level=2, go len=3 -> err pulse, seq_busy stays 0, no m_start.
  - go len=0 -> err pulse.
  - rx_level=7 (DEPTH 8), go len=2 -> err pulse.
- FIFO boundaries: push 9 bytes with DEPTH=8 -> tx_full=1 after the 8th push, 9th dropped, tx_level=8; rd_en on an empty RX leaves rx_level=0; 8 push/pop cycles exercise pointer wrap with data intact.
- Concurrent host activity: during a len=2 burst, push 0x77 and pop RX -> levels stay consistent; 0x77 remains in TX after done.
- SPI_SEQ_TIMEOUT_EN defined, TO_CYCLES=64, m_busy stuck at 0 -> err pulse 64 cycles after entering WAIT_BUSY; seq_busy=0; tx_level unchanged.

Source files
------------

// File: rtl/spi_burst_sequencer.sv
// Burst feeder for a single-byte SPI master: TX/RX byte FIFOs plus an issue/collect sequencer.
// Optional watchdog on the master handshake is enabled with `define SPI_SEQ_TIMEOUT_EN.
module spi_burst_sequencer #(
    parameter int DEPTH     = 8,
    parameter int AW        = 3,
    parameter int TO_CYCLES = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    output logic          tx_full,
    output logic [AW:0]   tx_level,
    input  logic          rd_en,
    output logic [7:0]    rd_data,
    output logic          rx_empty,
    output logic [AW:0]   rx_level,
    input  logic          go,
    input  logic [AW:0]   len,
    output logic          seq_busy,
    output logic          done,
    output logic          err,
    output logic          m_start,
    output logic [7:0]    m_data_in,
    input  logic          m_busy,
    input  logic [7:0]    m_data_out
);

    typedef enum logic [2:0] {
        IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, STORE, FINISH
    } state_t;

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    logic [7:0]    tx_mem_q [DEPTH];
    logic [7:0]    rx_mem_q [DEPTH];
    logic [AW-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
    logic [AW-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
    logic [AW:0]   tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;

    state_t        state_q, state_d;
    logic [AW:0]   remaining_q, remaining_d;
    logic          seq_busy_q, seq_busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          m_start_q, m_start_d;
    logic [7:0]    m_data_in_q, m_data_in_d;

    logic          tx_pop, rx_push, go_ok;
    logic          tx_push_ok, tx_pop_ok, rx_push_ok, rx_pop_ok;
    logic [7:0]    tx_head;

`ifdef SPI_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TO_CYCLES + 1);
    logic [TW-1:0] to_cnt_q, to_cnt_d;
`endif

    assign tx_head  = tx_mem_q[tx_rptr_q];
    assign tx_full  = (tx_cnt_q == DEPTH_L);
    assign tx_level = tx_cnt_q;
    assign rd_data  = rx_mem_q[rx_rptr_q];
    assign rx_empty = (rx_cnt_q == '0);
    assign rx_level = rx_cnt_q;
    assign seq_busy = seq_busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign m_start  = m_start_q;
    assign m_data_in = m_data_in_q;

    // Full/empty are judged on the pre-cycle count, so a push into a full TX is dropped even while popping.
    always_comb begin
        tx_push_ok = wr_en && !tx_full;
        tx_pop_ok  = tx_pop && (tx_cnt_q != '0);
        rx_push_ok = rx_push && (rx_cnt_q != DEPTH_L);
        rx_pop_ok  = rd_en && !rx_empty;
        tx_wptr_d  = tx_push_ok ? tx_wptr_q + AW'(1) : tx_wptr_q;
        tx_rptr_d  = tx_pop_ok  ? tx_rptr_q + AW'(1) : tx_rptr_q;
        rx_wptr_d  = rx_push_ok ? rx_wptr_q + AW'(1) : rx_wptr_q;
        rx_rptr_d  = rx_pop_ok  ? rx_rptr_q + AW'(1) : rx_rptr_q;
        tx_cnt_d   = tx_cnt_q + (AW+1)'(tx_push_ok) - (AW+1)'(tx_pop_ok);
        rx_cnt_d   = rx_cnt_q + (AW+1)'(rx_push_ok) - (AW+1)'(rx_pop_ok);
    end

    always_ff @(posedge clk) begin
        if (tx_push_ok) tx_mem_q[tx_wptr_q] <= wr_data;
        if (rx_push_ok) rx_mem_q[rx_wptr_q] <= m_data_out;
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        seq_busy_d  = seq_busy_q;
        m_data_in_d = m_data_in_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        m_start_d   = 1'b0;
        tx_pop      = 1'b0;
        rx_push     = 1'b0;
        go_ok       = (len != '0) && (len <= tx_cnt_q) && (len <= DEPTH_L - rx_cnt_q);
        // m_start and m_data_in are loaded on entry to ISSUE so both are valid during that cycle.
        case (state_q)
            IDLE: begin
                if (go) begin
                    if (go_ok) begin
                        remaining_d = len;
                        seq_busy_d  = 1'b1;
                        m_start_d   = 1'b1;
                        m_data_in_d = tx_head;
                        state_d     = ISSUE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ISSUE:     state_d = WAIT_BUSY;
            WAIT_BUSY: if (m_busy) state_d = WAIT_DONE;
            WAIT_DONE: begin
                if (!m_busy) begin
                    rx_push     = 1'b1;
                    tx_pop      = 1'b1;
                    remaining_d = remaining_q - (AW+1)'(1);
                    state_d     = STORE;
                end
            end
            STORE: begin
                if (remaining_q == '0) begin
                    state_d = FINISH;
                end else begin
                    m_start_d   = 1'b1;
                    m_data_in_d = tx_head;
                    state_d     = ISSUE;
                end
            end
            FINISH: begin
                done_d     = 1'b1;
                seq_busy_d = 1'b0;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
`ifdef SPI_SEQ_TIMEOUT_EN
        // Abort leaves the unsent byte at the TX head; nothing was popped for it yet.
        to_cnt_d = '0;
        if ((state_q == WAIT_BUSY || state_q == WAIT_DONE) && state_d == state_q) begin
            if (to_cnt_q == TW'(TO_CYCLES - 1)) begin
                state_d    = IDLE;
                seq_busy_d = 1'b0;
                err_d      = 1'b1;
            end else begin
                to_cnt_d = to_cnt_q + TW'(1);
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_wptr_q   <= '0;
            tx_rptr_q   <= '0;
            rx_wptr_q   <= '0;
            rx_rptr_q   <= '0;
            tx_cnt_q    <= '0;
            rx_cnt_q    <= '0;
            state_q     <= IDLE;
            remaining_q <= '0;
            seq_busy_q  <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            m_start_q   <= 1'b0;
            m_data_in_q <= 8'h00;
`ifdef SPI_SEQ_TIMEOUT_EN
            to_cnt_q    <= '0;
`endif
        end else begin
            tx_wptr_q   <= tx_wptr_d;
            tx_rptr_q   <= tx_rptr_d;
            rx_wptr_q   <= rx_wptr_d;
            rx_rptr_q   <= rx_rptr_d;
            tx_cnt_q    <= tx_cnt_d;
            rx_cnt_q    <= rx_cnt_d;
            state_q     <= state_d;
            remaining_q <= remaining_d;
            seq_busy_q  <= seq_busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            m_start_q   <= m_start_d;
            m_data_in_q <= m_data_in_d;
`ifdef SPI_SEQ_TIMEOUT_EN
            to_cnt_q    <= to_cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_spi_burst_sequencer.sv
// Directed bench for spi_burst_sequencer with a behavioural loopback SPI master model.
module tb_spi_burst_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       tx_full;
    logic [3:0] tx_level;
    logic       rd_en = 1'b0;
    logic [7:0] rd_data;
    logic       rx_empty;
    logic [3:0] rx_level;
    logic       go = 1'b0;
    logic [3:0] len = 4'd0;
    logic       seq_busy, done, err, m_start;
    logic [7:0] m_data_in;
    logic       m_busy = 1'b0;
    logic [7:0] m_data_out = 8'h00;

    int n_checks = 0;
    int n_fail = 0;
    int n_starts = 0;
    int n_dones = 0;
    logic       mst_en = 1'b1;
    logic       mst_pending = 1'b0;
    logic [7:0] mst_shift = 8'h00;
    int         mst_cnt = 0;

    spi_burst_sequencer #(.DEPTH(8), .AW(3), .TO_CYCLES(64)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
        .tx_full(tx_full), .tx_level(tx_level), .rd_en(rd_en), .rd_data(rd_data),
        .rx_empty(rx_empty), .rx_level(rx_level), .go(go), .len(len),
        .seq_busy(seq_busy), .done(done), .err(err), .m_start(m_start),
        .m_data_in(m_data_in), .m_busy(m_busy), .m_data_out(m_data_out)
    );

    always #5 clk = ~clk;

    // Loopback master: samples data_in the cycle after start, busy for 5 cycles, returns the same byte.
    always @(posedge clk) begin
        if (!rst_n || !mst_en) begin
            m_busy      <= 1'b0;
            mst_pending <= 1'b0;
            mst_cnt     <= 0;
        end else if (mst_pending) begin
            mst_shift   <= m_data_in;
            m_busy      <= 1'b1;
            mst_cnt     <= 4;
            mst_pending <= 1'b0;
        end else if (m_start && !m_busy) begin
            mst_pending <= 1'b1;
        end else if (m_busy) begin
            if (mst_cnt == 0) begin
                m_busy     <= 1'b0;
                m_data_out <= mst_shift;
            end else begin
                mst_cnt <= mst_cnt - 1;
            end
        end
    end

    always @(negedge clk) begin
        if (m_start) n_starts++;
        if (done) n_dones++;
    end

    task automatic push(input logic [7:0] b);
        wr_en = 1'b1; wr_data = b;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic pop();
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic pulse_go(input logic [3:0] l);
        go = 1'b1; len = l;
        @(negedge clk);
        go = 1'b0; len = 4'd0;
    endtask

    task automatic wait_done(input string name);
        int k;
        k = 0;
        while (done !== 1'b1 && k < 400) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (done !== 1'b1) begin n_fail++; $display("FAIL %s_done_timeout: done=%b after %0d cycles, want 1", name, done, k); end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_checks++;
        if ({tx_full, rx_empty, tx_level, rx_level, seq_busy, done, err, m_start, m_data_in} !== {1'b0, 1'b1, 4'd0, 4'd0, 4'b0000, 8'h00}) begin
            n_fail++;
            $display("FAIL reset_outputs: full=%b empty=%b txl=%0d rxl=%0d busy=%b done=%b err=%b start=%b din=%h",
                     tx_full, rx_empty, tx_level, rx_level, seq_busy, done, err, m_start, m_data_in);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fifo_bounds();
        for (int i = 0; i < 7; i++) push(8'h10 + 8'(i));
        n_checks++;
        if (tx_full !== 1'b0) begin n_fail++; $display("FAIL fifo_not_full_at7: got %b want 0", tx_full); end
        push(8'h17);
        n_checks++;
        if (tx_full !== 1'b1 || tx_level !== 4'd8) begin n_fail++; $display("FAIL fifo_full_at8: full=%b level=%0d want 1/8", tx_full, tx_level); end
        push(8'h18);
        n_checks++;
        if (tx_level !== 4'd8) begin n_fail++; $display("FAIL fifo_ninth_dropped: level=%0d want 8", tx_level); end
        pop();
        n_checks++;
        if (rx_level !== 4'd0 || rx_empty !== 1'b1) begin n_fail++; $display("FAIL fifo_pop_empty: level=%0d empty=%b want 0/1", rx_level, rx_empty); end
        pulse_go(4'd8);
        wait_done("fifo_burst8");
        n_checks++;
        if (rx_level !== 4'd8 || tx_level !== 4'd0) begin n_fail++; $display("FAIL fifo_burst8_levels: rx=%0d tx=%0d want 8/0", rx_level, tx_level); end
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (rd_data !== 8'h10 + 8'(i)) begin n_fail++; $display("FAIL fifo_wrap_data%0d: got %h want %h", i, rd_data, 8'h10 + 8'(i)); end
            pop();
        end
        n_checks++;
        if (rx_empty !== 1'b1) begin n_fail++; $display("FAIL fifo_drained: empty=%b want 1", rx_empty); end
    endtask

    task automatic test_loopback();
        logic [7:0] exp [3];
        int s0, d0;
        exp[0] = 8'hA5; exp[1] = 8'h3C; exp[2] = 8'h0F;
        for (int i = 0; i < 3; i++) push(exp[i]);
        s0 = n_starts; d0 = n_dones;
        pulse_go(4'd3);
        n_checks++;
        if (seq_busy !== 1'b1 || m_start !== 1'b1 || m_data_in !== 8'hA5) begin
            n_fail++; $display("FAIL loop_issue: busy=%b start=%b din=%h want 1/1/a5", seq_busy, m_start, m_data_in);
        end
        wait_done("loop");
        @(negedge clk);
        n_checks++;
        if (n_starts - s0 != 3 || n_dones - d0 != 1) begin n_fail++; $display("FAIL loop_pulses: starts=%0d dones=%0d want 3/1", n_starts - s0, n_dones - d0); end
        n_checks++;
        if (tx_level !== 4'd0 || rx_level !== 4'd3 || seq_busy !== 1'b0) begin
            n_fail++; $display("FAIL loop_levels: tx=%0d rx=%0d busy=%b want 0/3/0", tx_level, rx_level, seq_busy);
        end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (rd_data !== exp[i]) begin n_fail++; $display("FAIL loop_data%0d: got %h want %h", i, rd_data, exp[i]); end
            pop();
        end
    endtask

    task automatic test_illegal_go();
        int s0;
        push(8'h01); push(8'h02);
        s0 = n_starts;
        pulse_go(4'd3);
        n_checks++;
        if (err !== 1'b1 || seq_busy !== 1'b0) begin n_fail++; $display("FAIL illegal_len_gt_tx: err=%b busy=%b want 1/0", err, seq_busy); end
        repeat (5) @(negedge clk);
        n_checks++;
        if (err !== 1'b0 || n_starts != s0) begin n_fail++; $display("FAIL illegal_no_start: err=%b starts=%0d want 0/0", err, n_starts - s0); end
        pulse_go(4'd0);
        n_checks++;
        if (err !== 1'b1) begin n_fail++; $display("FAIL illegal_len0: err=%b want 1", err); end
        for (int i = 3; i < 8; i++) push(8'(i));
        pulse_go(4'd7);
        n_checks++;
        if (seq_busy !== 1'b1 || err !== 1'b0) begin n_fail++; $display("FAIL illegal_len7_accept: busy=%b err=%b want 1/0", seq_busy, err); end
        wait_done("fill7");
        push(8'h08); push(8'h09);
        n_checks++;
        if (rx_level !== 4'd7 || tx_level !== 4'd2) begin n_fail++; $display("FAIL illegal_pre_rx: rx=%0d tx=%0d want 7/2", rx_level, tx_level); end
        pulse_go(4'd2);
        n_checks++;
        if (err !== 1'b1 || seq_busy !== 1'b0) begin n_fail++; $display("FAIL illegal_rx_space: err=%b busy=%b want 1/0", err, seq_busy); end
        for (int i = 1; i < 7; i++) begin
            n_checks++;
            if (rd_data !== 8'(i)) begin n_fail++; $display("FAIL illegal_rx_data%0d: got %h want %h", i, rd_data, 8'(i)); end
            pop();
        end
    endtask

    task automatic test_concurrent_host();
        int s0;
        s0 = n_starts;
        pulse_go(4'd2);
        n_checks++;
        if (seq_busy !== 1'b1 || rd_data !== 8'h07) begin n_fail++; $display("FAIL conc_start: busy=%b head=%h want 1/07", seq_busy, rd_data); end
        wr_en = 1'b1; wr_data = 8'h77; rd_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0; rd_en = 1'b0;
        n_checks++;
        if (tx_level !== 4'd3 || rx_level !== 4'd0) begin n_fail++; $display("FAIL conc_levels: tx=%0d rx=%0d want 3/0", tx_level, rx_level); end
        wait_done("conc");
        n_checks++;
        if (tx_level !== 4'd1 || rx_level !== 4'd2 || n_starts - s0 != 2) begin
            n_fail++; $display("FAIL conc_after: tx=%0d rx=%0d starts=%0d want 1/2/2", tx_level, rx_level, n_starts - s0);
        end
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (rd_data !== 8'h08 + 8'(i)) begin n_fail++; $display("FAIL conc_data%0d: got %h want %h", i, rd_data, 8'h08 + 8'(i)); end
            pop();
        end
        pulse_go(4'd1);
        wait_done("conc_tail");
        n_checks++;
        if (rd_data !== 8'h77 || rx_level !== 4'd1) begin n_fail++; $display("FAIL conc_tail_data: got %h lvl=%0d want 77/1", rd_data, rx_level); end
        pop();
    endtask

    task automatic test_reset_mid_burst();
        int s0, k;
        for (int i = 0; i < 4; i++) push(8'hA1 + 8'(i));
        s0 = n_starts;
        pulse_go(4'd4);
        k = 0;
        while (!(n_starts - s0 == 2 && m_busy === 1'b1) && k < 200) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (k >= 200) begin n_fail++; $display("FAIL midrst_reach_byte2: starts=%0d busy=%b", n_starts - s0, m_busy); end
        @(negedge clk);
        n_checks++;
        if (rx_level !== 4'd1 || seq_busy !== 1'b1) begin n_fail++; $display("FAIL midrst_pre: rx=%0d busy=%b want 1/1", rx_level, seq_busy); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({tx_full, rx_empty, tx_level, rx_level, seq_busy, done, err, m_start, m_data_in} !== {1'b0, 1'b1, 4'd0, 4'd0, 4'b0000, 8'h00}) begin
            n_fail++;
            $display("FAIL midrst_outputs: full=%b empty=%b txl=%0d rxl=%0d busy=%b done=%b err=%b start=%b din=%h",
                     tx_full, rx_empty, tx_level, rx_level, seq_busy, done, err, m_start, m_data_in);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_stuck_master();
        mst_en = 1'b0;
        push(8'hB1); push(8'hB2);
        pulse_go(4'd2);
        n_checks++;
        if (m_start !== 1'b1) begin n_fail++; $display("FAIL stuck_issue: start=%b want 1", m_start); end
        repeat (64) @(negedge clk);
        n_checks++;
        if (err !== 1'b0 || seq_busy !== 1'b1) begin n_fail++; $display("FAIL stuck_before_limit: err=%b busy=%b want 0/1", err, seq_busy); end
        @(negedge clk);
`ifdef SPI_SEQ_TIMEOUT_EN
        n_checks++;
        if (err !== 1'b1 || seq_busy !== 1'b0 || tx_level !== 4'd2) begin
            n_fail++; $display("FAIL timeout_abort: err=%b busy=%b tx=%0d want 1/0/2", err, seq_busy, tx_level);
        end
`else
        repeat (40) @(negedge clk);
        n_checks++;
        if (err !== 1'b0 || seq_busy !== 1'b1 || tx_level !== 4'd2) begin
            n_fail++; $display("FAIL stuck_waits: err=%b busy=%b tx=%0d want 0/1/2", err, seq_busy, tx_level);
        end
`endif
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        mst_en = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_fifo_bounds();
        test_loopback();
        test_illegal_go();
        test_concurrent_host();
        test_reset_mid_burst();
        test_stuck_master();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
